captura_operandos: RTL

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

---
 rtl/captura_operandos_pkg.sv | 15 +
 rtl/captura_operandos_debounce_botao.sv | 62 ++++++
 rtl/captura_operandos.sv | 106 ++++++++++
 3 files changed

// File: rtl/captura_operandos_pkg.sv
// Shared state codes and debounce default for the operand-capture
// block and the board top level.
package captura_operandos_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 500000;

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    EXECUTA   = 3'd3,
    MOSTRA    = 3'd4
  } estado_t;

endpackage

// File: rtl/captura_operandos_debounce_botao.sv
// Pushbutton conditioner: 2-flop sync, debouncer and press-edge
// detector producing a one-cycle event per accepted press.
module debounce_botao #(
  parameter int unsigned CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic evento_o
);

  localparam int CW = $clog2(CICLOS + 1);
  localparam logic [CW-1:0] LIM = CW'(CICLOS - 1);

  logic          s1_q, s2_q;
  logic          est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ant_q;
  logic [1:0]    vld_q;
  logic          bloq_q, bloq_d;
  logic          evt_q, evt_d;
  logic          prs;

  always_comb begin
    prs    = ~s2_q;
    est_d  = est_q;
    cnt_d  = '0;
    if (prs != est_q) begin
      if (cnt_q == LIM) est_d = prs;
      else              cnt_d = cnt_q + 1'b1;
    end
    // After reset, stay blocked until a real released level is seen,
    // so a button held through reset never yields an event.
    bloq_d = bloq_q & ~(vld_q[1] & s2_q & ~est_q);
    evt_d  = est_q & ~ant_q & ~bloq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      est_q  <= 1'b0;
      cnt_q  <= '0;
      ant_q  <= 1'b0;
      vld_q  <= 2'b00;
      bloq_q <= 1'b1;
      evt_q  <= 1'b0;
    end else begin
      s1_q   <= btn_n_i;
      s2_q   <= s1_q;
      est_q  <= est_d;
      cnt_q  <= cnt_d;
      ant_q  <= est_q;
      vld_q  <= {vld_q[0], 1'b1};
      bloq_q <= bloq_d;
      evt_q  <= evt_d;
    end
  end

  assign evento_o = evt_q;

endmodule

// File: rtl/captura_operandos.sv
// Step-by-step operand entry for the board ALU: A, B, then
// operation/carry, confirmed and cancelled by pushbuttons.
module captura_operandos
  import captura_operandos_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] SW,
  input  logic       btn_avanca_n,
  input  logic       btn_cancela_n,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       carry_in,
  output logic [1:0] seletor,
  output logic       op_valid,
  output logic [2:0] estado
);

  estado_t    estado_q, estado_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       cin_q, cin_d;
  logic [1:0] sel_q, sel_d;
  logic       ov_q, ov_d;
  logic       conf, canc;
  logic       sw_unused;

  assign sw_unused = ^SW[6:4];

  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_avanca (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_avanca_n),
    .evento_o(conf)
  );

  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_cancela (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (btn_cancela_n),
    .evento_o(canc)
  );

  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    sel_d    = sel_q;
    if (canc) begin
      estado_d = ESPERA_A;
      a_d      = '0;
      b_d      = '0;
      cin_d    = 1'b0;
      sel_d    = '0;
    end else begin
      case (estado_q)
        ESPERA_A: if (conf) begin
          a_d      = SW[3:0];
          estado_d = ESPERA_B;
        end
        ESPERA_B: if (conf) begin
          b_d      = SW[3:0];
          estado_d = ESPERA_OP;
        end
        ESPERA_OP: if (conf) begin
          sel_d    = SW[9:8];
          cin_d    = SW[7];
          estado_d = EXECUTA;
        end
        EXECUTA:  estado_d = MOSTRA;
        MOSTRA:   if (conf) estado_d = ESPERA_A;
        default:  estado_d = ESPERA_A;
      endcase
    end
    // Registered alongside the state, so it is high exactly in EXECUTA.
    ov_d = (estado_d == EXECUTA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESPERA_A;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      sel_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      sel_q    <= sel_d;
      ov_q     <= ov_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign carry_in = cin_q;
  assign seletor  = sel_q;
  assign op_valid = ov_q;
  assign estado   = estado_q;

endmodule
